// File: rtl/data_mem_responder_if.sv
// Purpose: request/response bundle between the data cache and the memory responder.
// Latency: none, this is wiring only.
// Backpressure: the responder holds free low while busy; the cache must wait for free=1.
interface data_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [1:0]              rw_flag;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   i_data;
    logic [DATA_WIDTH/8-1:0] i_mask;
    logic                    free;
    logic                    read_valid;
    logic [DATA_WIDTH-1:0]   o_data;

    // Cache side: issues requests, consumes status and read data
    modport master (
        output rw_flag, addr, i_data, i_mask,
        input  free, read_valid, o_data
    );

    // Memory side: consumes requests, produces status and read data
    modport slave (
        input  rw_flag, addr, i_data, i_mask,
        output free, read_valid, o_data
    );
endinterface

// File: rtl/data_mem_responder.sv
// Purpose: word-organised data RAM answering one cache request at a time.
// Latency: LATENCY cycles from accept to completion; read_valid pulses the cycle after.
// Backpressure: free=0 while busy; requests presented while busy are dropped.
// Build option: define DMEM_BYTE_MASK_EN to honour i_mask per byte on writes;
// without it every write stores the full word and i_mask is ignored.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_responder_if.slave   bus
);
    localparam int MASK_W = DATA_WIDTH / 8;
    localparam int DEPTH  = 1 << DEPTH_LOG2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    accept;
    logic                    complete;

    // Latched request; inputs are not looked at again once BUSY
    logic                    op_write_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    logic                    read_valid_q;
    logic [DATA_WIDTH-1:0]   o_data_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    req_vld;
    logic                    req_write;
    logic [DEPTH_LOG2-1:0]   req_idx;

    // Only 01 (read) and 10 (write) are requests; 11 is treated as idle
    assign req_vld   = (bus.rw_flag == 2'b01) || (bus.rw_flag == 2'b10);
    assign req_write = (bus.rw_flag == 2'b10);
    // Byte offset and bits above the RAM size are dropped, so addresses wrap
    assign req_idx   = bus.addr[DEPTH_LOG2+1:2];

`ifdef DMEM_BYTE_MASK_EN
    logic [MASK_W-1:0]       mask_q;
    logic                    unused_addr;
    assign unused_addr = ^{bus.addr[1:0], bus.addr[ADDR_WIDTH-1:DEPTH_LOG2+2]};
`else
    logic                    unused_addr_mask;
    assign unused_addr_mask = ^{bus.addr[1:0], bus.addr[ADDR_WIDTH-1:DEPTH_LOG2+2], bus.i_mask};
`endif

    // State register and down-counter; reset aborts any in-flight op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: accept in IDLE, count down in BUSY, complete when counter hits zero
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Capture the request on the accepting edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
`ifdef DMEM_BYTE_MASK_EN
            mask_q     <= '0;
`endif
        end else if (accept) begin
            op_write_q <= req_write;
            idx_q      <= req_idx;
            wdata_q    <= bus.i_data;
`ifdef DMEM_BYTE_MASK_EN
            mask_q     <= bus.i_mask;
`endif
        end
    end

    // Read completion: one-cycle valid pulse, data held until the next read completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_valid_q <= 1'b0;
            o_data_q     <= '0;
        end else begin
            read_valid_q <= complete && !op_write_q;
            if (complete && !op_write_q) begin
                o_data_q <= mem[idx_q];
            end
        end
    end

    // Write commit at completion; RAM contents survive reset
    always_ff @(posedge clk) begin
        if (complete && op_write_q) begin
`ifdef DMEM_BYTE_MASK_EN
            for (int k = 0; k < MASK_W; k++) begin
                if (mask_q[k]) begin
                    mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
`else
            mem[idx_q] <= wdata_q;
`endif
        end
    end

    assign bus.free       = (state_q == IDLE);
    assign bus.read_valid = read_valid_q;
    assign bus.o_data     = o_data_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: reset, read/write latency, masking,
// address wrap, busy-time request dropping, abort on reset and back-to-back reads.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    data_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    data_mem_responder #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH_LOG2(10),
        .LATENCY(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

`ifdef DMEM_BYTE_MASK_EN
    localparam logic [31:0] MASKED_EXP = 32'hDE22BE44;
`else
    localparam logic [31:0] MASKED_EXP = 32'h11223344;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: issue one request, then sample until free returns.
    task automatic do_op(input logic [1:0] flag, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, output int lat, output logic rv_done,
                         output logic [31:0] dat_done, output logic rv_after);
        int w;
        w = 0;
        while (bus.free !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        bus.rw_flag = flag;
        bus.addr    = a;
        bus.i_data  = d;
        bus.i_mask  = m;
        @(negedge clk);
        bus.rw_flag = 2'b00;
        lat = 0;
        while (bus.free !== 1'b1 && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        rv_done  = bus.read_valid;
        dat_done = bus.o_data;
        @(negedge clk);
        rv_after = bus.read_valid;
    endtask

    initial begin
        int          lat;
        logic        rv, rv2;
        logic [31:0] dat;
        logic        seen_busy, seen_pulse;
        int          npulse, first_pos, second_pos;

        bus.rw_flag = 2'b00;
        bus.addr    = '0;
        bus.i_data  = '0;
        bus.i_mask  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_free", 32'(bus.free), 32'd1);
        chk("reset_rv", 32'(bus.read_valid), 32'd0);
        chk("reset_odata", bus.o_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Full write then read of the same word
        do_op(2'b10, 32'h10, 32'hDEADBEEF, 4'hF, lat, rv, dat, rv2);
        chk("wr_latency", 32'(lat), 32'd4);
        chk("wr_no_pulse", 32'(rv), 32'd0);
        do_op(2'b01, 32'h10, 32'h0, 4'h0, lat, rv, dat, rv2);
        chk("rd_latency", 32'(lat), 32'd4);
        chk("rd_pulse", 32'(rv), 32'd1);
        chk("rd_data", dat, 32'hDEADBEEF);
        chk("rd_pulse_width", 32'(rv2), 32'd0);

        // Partial mask write over the existing word
        do_op(2'b10, 32'h10, 32'h11223344, 4'b0101, lat, rv, dat, rv2);
        do_op(2'b01, 32'h10, 32'h0, 4'h0, lat, rv, dat, rv2);
        chk("mask_data", dat, MASKED_EXP);

        // Address wrap and ignored byte offset
        do_op(2'b10, 32'h1000, 32'hA5A5A5A5, 4'hF, lat, rv, dat, rv2);
        do_op(2'b01, 32'h0, 32'h0, 4'h0, lat, rv, dat, rv2);
        chk("wrap_data", dat, 32'hA5A5A5A5);
        do_op(2'b01, 32'h13, 32'h0, 4'h0, lat, rv, dat, rv2);
        chk("offset_data", dat, MASKED_EXP);

        // Requests presented while busy are dropped
        do_op(2'b10, 32'h20, 32'h12345678, 4'hF, lat, rv, dat, rv2);
        bus.rw_flag = 2'b01;
        bus.addr    = 32'h10;
        @(negedge clk);
        bus.rw_flag = 2'b10;
        bus.addr    = 32'h20;
        bus.i_data  = 32'hFFFFFFFF;
        bus.i_mask  = 4'hF;
        lat = 0;
        while (bus.free !== 1'b1 && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        bus.rw_flag = 2'b00;
        chk("busy_rd_latency", 32'(lat), 32'd4);
        chk("busy_rd_pulse", 32'(bus.read_valid), 32'd1);
        chk("busy_rd_data", bus.o_data, MASKED_EXP);
        @(negedge clk);
        do_op(2'b01, 32'h20, 32'h0, 4'h0, lat, rv, dat, rv2);
        chk("busy_wr_dropped", dat, 32'h12345678);

        // rw_flag=11 is idle
        bus.rw_flag = 2'b11;
        seen_busy  = 1'b0;
        seen_pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen_busy  = seen_busy | (bus.free !== 1'b1);
            seen_pulse = seen_pulse | (bus.read_valid !== 1'b0);
        end
        bus.rw_flag = 2'b00;
        chk("flag11_busy", 32'(seen_busy), 32'd0);
        chk("flag11_pulse", 32'(seen_pulse), 32'd0);
        @(negedge clk);

        // Abort a write with reset while counter=1
        do_op(2'b10, 32'h40, 32'h0, 4'hF, lat, rv, dat, rv2);
        bus.rw_flag = 2'b10;
        bus.addr    = 32'h40;
        bus.i_data  = 32'h55;
        bus.i_mask  = 4'hF;
        @(negedge clk);
        bus.rw_flag = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy", 32'(bus.free), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_free", 32'(bus.free), 32'd1);
        chk("async_rst_rv", 32'(bus.read_valid), 32'd0);
        chk("async_rst_odata", bus.o_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(2'b01, 32'h40, 32'h0, 4'h0, lat, rv, dat, rv2);
        chk("abort_not_committed", dat, 32'h0);

        // Back-to-back reads with rw_flag held
        bus.rw_flag = 2'b01;
        bus.addr    = 32'h10;
        npulse     = 0;
        first_pos  = -1;
        second_pos = -1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.read_valid === 1'b1) begin
                if (npulse == 0) first_pos = i;
                else if (npulse == 1) second_pos = i;
                npulse++;
            end
        end
        bus.rw_flag = 2'b00;
        chk("b2b_count", 32'(npulse), 32'd3);
        chk("b2b_first", 32'(first_pos), 32'd4);
        chk("b2b_spacing", 32'(second_pos - first_pos), 32'd5);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
